// File: rtl/pattern_detector.sv
// Serial bit-pattern detector: programmable pattern and length, optional
// overlapping matches, Mealy or registered match output, saturating match counter.
module pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int REG_OUT = 0,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in,
  input  logic               clr_count,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(5);
  localparam logic [LEN_W-1:0]   RST_LEN     = LEN_W'(3);
  localparam logic [LEN_W-1:0]   MAX_LEN_L   = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic               match_q;

  logic [MAX_LEN-1:0] shifted;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len_eff;
  logic [LEN_W:0]     fill_inc;
  logic               hit;

  // cfg_len is wide enough to exceed MAX_LEN, so clamp before use.
  assign len_eff  = (len_q > MAX_LEN_L) ? MAX_LEN_L : len_q;
  assign shifted  = {hist[MAX_LEN-2:0], in};
  assign fill_inc = {1'b0, fill} + (LEN_W + 1)'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_eff));
    end
  end

  assign hit = in_valid && !cfg_load && (len_eff != '0)
               && (fill_inc >= {1'b0, len_eff})
               && ((shifted & mask) == (pattern_q & mask));

  assign match = (REG_OUT != 0) ? match_q : hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q   <= RST_PATTERN;
      len_q       <= RST_LEN;
      overlap_q   <= 1'b1;
      hist        <= '0;
      fill        <= '0;
      match_q     <= 1'b0;
      match_count <= '0;
    end else begin
      match_q <= hit;

      if (cfg_load) begin
        pattern_q <= cfg_pattern;
        len_q     <= cfg_len;
        overlap_q <= cfg_overlap;
        hist      <= '0;
        fill      <= '0;
      end else if (in_valid) begin
        hist <= shifted;
        // Non-overlap: the completing bit must not seed the next match.
        if (hit && !overlap_q) begin
          fill <= '0;
        end else if (fill < MAX_LEN_L) begin
          fill <= fill_inc[LEN_W-1:0];
        end
      end

      if (clr_count) begin
        match_count <= '0;
      end else if (hit && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pattern_detector.sv
// Self-checking bench for pattern_detector: Mealy, registered and narrow-counter
// instances share one stimulus stream; expected matches come from a queue.
module tb_pattern_detector;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               in_valid = 1'b0;
  logic               in = 1'b0;
  logic               clr_count = 1'b0;

  logic       match0, match1, match2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;
  int exp_cnt0 = 0;
  int exp_cnt2 = 0;
  logic exp_q[$];
  logic exp_q1[$];

  pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(8), .REG_OUT(0)) dut0 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in(in),
    .clr_count(clr_count), .match(match0), .match_count(cnt0));

  pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(8), .REG_OUT(1)) dut1 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in(in),
    .clr_count(clr_count), .match(match1), .match_count(cnt1));

  pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(2), .REG_OUT(0)) dut2 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in(in),
    .clr_count(clr_count), .match(match2), .match_count(cnt2));

  always #5 clk = ~clk;

  // One cycle of stimulus; returns at the following negedge. Also advances the
  // expected counter values from the bench's own expected hit.
  task automatic drive(input logic v, input logic b, input logic ld,
                       input logic clr, input logic exp_hit);
    @(posedge clk); #1;
    in_valid  = v;
    in        = b;
    cfg_load  = ld;
    clr_count = clr;
    if (clr) begin
      exp_cnt0 = 0;
      exp_cnt2 = 0;
    end else if (exp_hit) begin
      if (exp_cnt0 < 255) exp_cnt0++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                         input logic o);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0; in = 1'b0; cfg_load = 1'b0; clr_count = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt0 = 0;
    exp_cnt2 = 0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in = 1'b1;
    @(negedge clk);
    checks++;
    if (match0 !== 1'b0) begin errors++; $display("FAIL reset_match0 got %0b exp 0", match0); end
    checks++;
    if (match1 !== 1'b0) begin errors++; $display("FAIL reset_match1 got %0b exp 0", match1); end
    checks++;
    if (cnt0 !== 8'd0) begin errors++; $display("FAIL reset_cnt0 got %0d exp 0", cnt0); end
    checks++;
    if (cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt2 got %0d exp 0", cnt2); end
    pulse_reset();
  endtask

  // Default 101 overlapping; also checks the registered instance one cycle late.
  task automatic test_default();
    logic [4:0] s = 5'b10101;
    logic [4:0] x = 5'b00101;
    logic e;
    exp_q1.delete();
    exp_q1.push_back(1'b0);
    for (int i = 4; i >= 0; i--) begin
      exp_q.push_back(x[i]);
      exp_q1.push_back(x[i]);
      drive(1'b1, s[i], 1'b0, 1'b0, x[i]);
      e = exp_q.pop_front();
      checks++;
      if (match0 !== e) begin errors++; $display("FAIL default_match bit%0d got %0b exp %0b", 5 - i, match0, e); end
      e = exp_q1.pop_front();
      checks++;
      if (match1 !== e) begin errors++; $display("FAIL regout_match bit%0d got %0b exp %0b", 5 - i, match1, e); end
    end
    exp_q1.push_back(1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e = exp_q1.pop_front();
    checks++;
    if (match1 !== e) begin errors++; $display("FAIL regout_late got %0b exp %0b", match1, e); end
    checks++;
    if (match0 !== 1'b0) begin errors++; $display("FAIL default_idle got %0b exp 0", match0); end
    checks++;
    if (cnt0 !== 8'(exp_cnt0)) begin errors++; $display("FAIL default_count got %0d exp %0d", cnt0, exp_cnt0); end
  endtask

  task automatic test_overlap();
    logic [6:0] s = 7'b1101101;
    logic [6:0] x;
    logic e;
    for (int pass = 0; pass < 2; pass++) begin
      x = (pass == 0) ? 7'b0001000 : 7'b0001001;
      set_cfg(8'b0000_1101, 4'd4, pass[0]);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 6; i >= 0; i--) begin
        exp_q.push_back(x[i]);
        drive(1'b1, s[i], 1'b0, 1'b0, x[i]);
        e = exp_q.pop_front();
        checks++;
        if (match0 !== e) begin errors++; $display("FAIL overlap%0d_match bit%0d got %0b exp %0b", pass, 7 - i, match0, e); end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt0 !== 8'(exp_cnt0)) begin errors++; $display("FAIL overlap_count got %0d exp %0d", cnt0, exp_cnt0); end
  endtask

  task automatic test_saturation();
    logic e;
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back((i >= 2) && (i % 2 == 0));
      drive(1'b1, (i % 2 == 0), 1'b0, 1'b0, (i >= 2) && (i % 2 == 0));
      e = exp_q.pop_front();
      checks++;
      if (match0 !== e) begin errors++; $display("FAIL sat_match bit%0d got %0b exp %0b", i + 1, match0, e); end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt2 !== 2'(exp_cnt2)) begin errors++; $display("FAIL sat_cnt2 got %0d exp %0d", cnt2, exp_cnt2); end
    checks++;
    if (cnt0 !== 8'(exp_cnt0)) begin errors++; $display("FAIL sat_cnt0 got %0d exp %0d", cnt0, exp_cnt0); end
    exp_q.push_back(1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (match0 !== e) begin errors++; $display("FAIL clr_hit_match got %0b exp %0b", match0, e); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt2 !== 2'(exp_cnt2)) begin errors++; $display("FAIL clr_cnt2 got %0d exp %0d", cnt2, exp_cnt2); end
    checks++;
    if (cnt0 !== 8'(exp_cnt0)) begin errors++; $display("FAIL clr_cnt0 got %0d exp %0d", cnt0, exp_cnt0); end
  endtask

  task automatic test_reset_mid();
    logic [4:0] s = 5'b10101;
    logic [4:0] x = 5'b00001;
    logic [7:0] sc = 8'hA5;
    logic [7:0] xc = 8'b0000_0001;
    logic e;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_reset();
    // After reset: 1,0,1 must be seen again in full; the first 1 alone is not enough.
    for (int i = 2; i >= 0; i--) begin
      exp_q.push_back(x[i]);
      drive(1'b1, s[i], 1'b0, 1'b0, x[i]);
      e = exp_q.pop_front();
      checks++;
      if (match0 !== e) begin errors++; $display("FAIL rstmid_match bit%0d got %0b exp %0b", 3 - i, match0, e); end
    end
    set_cfg(8'b0000_0000, 4'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) begin
      exp_q.push_back(1'b0);
      drive(1'b1, s[i], 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (match0 !== e) begin errors++; $display("FAIL len0_match bit%0d got %0b exp %0b", 5 - i, match0, e); end
    end
    set_cfg(8'hA5, 4'd15, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(xc[i]);
      drive(1'b1, sc[i], 1'b0, 1'b0, xc[i]);
      e = exp_q.pop_front();
      checks++;
      if (match0 !== e) begin errors++; $display("FAIL clamp_match bit%0d got %0b exp %0b", 8 - i, match0, e); end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt0 !== 8'(exp_cnt0)) begin errors++; $display("FAIL rstmid_count got %0d exp %0d", cnt0, exp_cnt0); end
  endtask

  task automatic test_idle();
    logic e;
    set_cfg(8'b0000_0101, 4'd3, 1'b1);
    exp_q.push_back(1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (match0 !== e) begin errors++; $display("FAIL load_cycle_match got %0b exp %0b", match0, e); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (match0 !== e) begin errors++; $display("FAIL idle_match cyc%0d got %0b exp %0b", i, match0, e); end
    end
    exp_q.push_back(1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (match0 !== e) begin errors++; $display("FAIL after_idle_match got %0b exp %0b", match0, e); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(i == 2);
      drive(1'b1, (i != 1), 1'b0, 1'b0, (i == 2));
      e = exp_q.pop_front();
      checks++;
      if (match0 !== e) begin errors++; $display("FAIL after_load_match bit%0d got %0b exp %0b", i + 1, match0, e); end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt0 !== 8'(exp_cnt0)) begin errors++; $display("FAIL idle_count got %0d exp %0d", cnt0, exp_cnt0); end
  endtask

  initial begin
    test_reset();
    test_default();
    test_overlap();
    test_saturation();
    test_reset_mid();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum supported pattern length in bits (2..32).
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-003 SHALL have parameter REG_OUT, default 0; 0 = Mealy (combinational) match, 1 = match registered one cycle later.
REQ-004 SHALL have localparam LEN_W = $clog2(MAX_LEN+1).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 cfg_load  input  1  latch cfg_pattern/cfg_len/cfg_overlap this cycle.
REQ-008 cfg_pattern  input  MAX_LEN  pattern; bit 0 = last-received bit, bit cfg_len-1 = first-received bit.
REQ-009 cfg_len  input  LEN_W  pattern length in bits.
REQ-010 cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history restarts after a match.
REQ-011 in_valid  input  1  serial bit qualifier.
REQ-012 in  input  1  serial data bit.
REQ-013 clr_count  input  1  synchronous clear of match_count.
REQ-014 match  output  1  pattern completed (timing per REQ-019/020).
REQ-015 match_count  output  CNT_W  saturating count of matches.

Function
REQ-016 SHALL keep history register hist[MAX_LEN-1:0] (newest bit at bit 0) and fill counter fill (0..MAX_LEN, saturating).
REQ-017 On in_valid with no cfg_load: hist <= {hist[MAX_LEN-2:0], in}; fill <= min(fill+1, MAX_LEN).
REQ-018 Hit SHALL be in_valid & len_eff != 0 & fill+1 >= len_eff & low len_eff bits of {hist[MAX_LEN-2:0], in} == low len_eff bits of stored pattern.
REQ-019 REG_OUT=0: match = hit, combinational in the same cycle as the completing bit.
REQ-020 REG_OUT=1: match = hit registered, asserted exactly one cycle after the completing bit, for one cycle.
REQ-021 len_eff SHALL be stored cfg_len clamped to MAX_LEN; len_eff = 0 disables detection (match never asserts).
REQ-022 Non-overlap mode: on hit, fill SHALL be set to 0 (the completing bit is not reused); hist is still shifted.
REQ-023 Overlap mode: on hit, fill SHALL update per REQ-017.
REQ-024 Idle cycles (in_valid=0) SHALL not change hist, fill or match_count; match=0 for that cycle (REG_OUT=0).
REQ-025 cfg_load SHALL latch config, clear hist and fill to 0, suppress hit that cycle, and ignore in that cycle; match_count is unaffected.
REQ-026 match_count SHALL increment by 1 on each hit and saturate at 2^CNT_W-1.
REQ-027 clr_count SHALL set match_count to 0 and take priority over a simultaneous hit (result 0).

Reset
REQ-028 Reset SHALL set pattern = 3'b101 (zero-extended), len = 3, overlap = 1, hist = 0, fill = 0, match_count = 0, registered match = 0.
REQ-029 Reset asserted mid-sequence SHALL discard partial history; the next match requires a full len_eff bits after release.
REQ-030 With REG_OUT=0 during reset, match SHALL be 0 (fill = 0 forces no hit for len_eff >= 2).

Verification
REQ-031 Defaults, REG_OUT=0, stream 1,0,1,0,1 -> match high on bits 3 and 5; match_count = 2.
REQ-032 Load pattern 4'b1101 len 4 overlap 0, stream 1,1,0,1,1,0,1 -> match on bit 4 only; with overlap 1 -> match on bits 4 and 7.
REQ-033 REG_OUT=1, defaults, stream 1,0,1 -> match high one cycle after bit 3, low otherwise.
REQ-034 CNT_W=2, defaults, stream of 1,0 repeated 10 times -> match_count saturates at 3; clr_count concurrent with a hit -> 0.
REQ-035 Stream 1,0 then reset pulse then 1 -> no match; cfg_load with cfg_len=0 then any stream -> match never asserts.
REQ-036 Stream 1,0, idle 5 cycles (in_valid=0), then 1 -> match on that 1; cfg_load between 1,0 and 1 -> no match.
